rr_arbiter8: RTL and testbench
==============================

// Module: rr_arbiter8
// PURPOSE
//   8-requester round-robin arbiter with bounded hold (lock) time, sharing one
//   resource (e.g. bus/memory port) among 8 masters. Uses or8way for the
//   any-request detect. Registered one-hot grant plus encoded id for the mux select.
// PARAMETERS
//   MAX_HOLD  16  max consecutive cycles one holder keeps grant while others wait (>=1)
//   HOLD_W    5   counter width; must satisfy 2**HOLD_W > MAX_HOLD
// PORTS
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous active-low reset
//   req        in   8  request per master; bit i high = master i wants resource
//   gnt        out  8  registered one-hot grant; all-zero when idle
//   gnt_id     out  3  binary index of current holder; valid only when gnt_valid
//   gnt_valid  out  1  registered; high iff gnt != 0
//   any_req    out  1  combinational OR of req[7:0] (or8way instance)
//   preempt    out  1  registered 1-cycle pulse: grant rotated by hold timeout
// BEHAVIOUR
//   Reset (async assert, sync release): gnt=0, gnt_id=0, gnt_valid=0, preempt=0,
//     ptr=0, hold_cnt=0, state=IDLE. Reset mid-grant drops grant immediately.
//   Arbitration: winner = first set req bit scanning ptr, ptr+1, ... wrap 7->0.
//     On every new grant to master k: ptr <= (k+1) mod 8, hold_cnt <= 0.
//   States:
//     IDLE : any_req=0 -> stay. any_req=1 -> grant winner at next edge, go GRANT.
//     GRANT: holder h, others = req & ~(1<<h).
//       req[h]=0, others!=0 -> grant new winner same edge (no bubble).
//       req[h]=0, others==0 -> gnt<=0, go IDLE.
//       req[h]=1, hold_cnt==MAX_HOLD-1, others!=0 -> rotate to winner of
//         others, preempt<=1 for that cycle.
//       req[h]=1, otherwise -> keep grant; hold_cnt increments, saturating at
//         MAX_HOLD-1 (no wrap) while no other requester waits.
//   Latency: req rising at edge n sampled -> gnt at edge n+1 (1 cycle).
//     Dropping req[h] -> gnt[h] cleared at next edge.
//   Invariants: gnt one-hot or zero; gnt_id matches gnt; gnt only asserted on
//     a bit whose req was high at the granting edge; any master with steady
//     req is granted within 7*MAX_HOLD+8 cycles (starvation-free).
//   Simultaneous release and timeout: release takes precedence (no preempt pulse).
//   Requests deasserted by non-holders are ignored; no request is latched.
//   X on req after reset: treated as don't-care only for masked (non-scanned) bits.
// TESTING
//   1 Reset: rst_n=0 with req=8'hFF -> gnt=0, gnt_valid=0, preempt=0 throughout,
//     async (no clk edge needed).
//   2 Single: req=8'h04 from idle -> gnt=8'h04, gnt_id=2 one cycle later; drop
//     req -> gnt=0 next cycle, state IDLE.
//   3 Rotation: req=8'hFF, each holder releases after 1 cycle -> grant order
//     0,1,2,...,7,0 with no idle cycles between grants.
//   4 Timeout: MAX_HOLD=4, req=8'h09 held constant -> master 0 holds 4 cycles,
//     preempt pulses, master 3 holds 4 cycles, preempt, back to 0.
//   5 Saturation: req=8'h20 only, held 40 cycles with MAX_HOLD=4 -> gnt stays
//     8'h20, no preempt; raise req[1] -> rotation to 1 at the next edge.
//   6 Reset mid-grant: holder 5 at hold_cnt=2, pulse rst_n low -> gnt=0 at once;
//     after release with req=8'h21 -> master 0 granted first (ptr reset to 0).

Source files
------------

// File: rtl/rr_arbiter8.sv
// Eight-master round-robin arbiter with a bounded hold time. It produces a registered one-hot
// grant, an encoded holder id and a one-cycle pulse whenever a hold timeout forces a rotation.

module or8way (
    input  logic [7:0] vec,
    output logic       hit
);
    logic [3:0] pair;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_pair
            assign pair[gi] = vec[2*gi] | vec[2*gi+1];
        end
    endgenerate

    assign hit = |pair;
endmodule

module rr_arbiter8 #(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       any_req,
    output logic       preempt
);
    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t            state_reg, state_next;
    logic [7:0]        gnt_reg, gnt_next;
    logic [2:0]        gnt_id_reg, gnt_id_next;
    logic              gnt_valid_reg;
    logic              preempt_reg, preempt_next;
    logic [2:0]        ptr_reg, ptr_next;
    logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;

    logic [7:0] others;
    logic [7:0] scan_mask;
    logic [2:0] win;
    logic [2:0] scan_idx;
    logic       win_found;

    or8way u_any (
        .vec (req),
        .hit (any_req)
    );

    assign others    = req & ~(8'd1 << gnt_id_reg);
    assign scan_mask = (state_reg == GRANT) ? others : req;

    // First set bit of scan_mask starting at ptr and wrapping 7 -> 0.
    always_comb begin
        win       = 3'd0;
        win_found = 1'b0;
        scan_idx  = 3'd0;
        for (int i = 0; i < 8; i++) begin
            scan_idx = ptr_reg + 3'(i);
            if (!win_found && scan_mask[scan_idx]) begin
                win       = scan_idx;
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        gnt_next      = gnt_reg;
        gnt_id_next   = gnt_id_reg;
        ptr_next      = ptr_reg;
        hold_cnt_next = hold_cnt_reg;
        preempt_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    state_next    = GRANT;
                    gnt_next      = 8'd1 << win;
                    gnt_id_next   = win;
                    ptr_next      = win + 3'd1;
                    hold_cnt_next = '0;
                end
            end
            GRANT: begin
                if (!req[gnt_id_reg]) begin
                    // Release wins over timeout, so no preempt pulse here.
                    if (others != 8'd0) begin
                        gnt_next      = 8'd1 << win;
                        gnt_id_next   = win;
                        ptr_next      = win + 3'd1;
                        hold_cnt_next = '0;
                    end else begin
                        state_next = IDLE;
                        gnt_next   = 8'd0;
                    end
                end else if (hold_cnt_reg == HOLD_LAST && others != 8'd0) begin
                    gnt_next      = 8'd1 << win;
                    gnt_id_next   = win;
                    ptr_next      = win + 3'd1;
                    hold_cnt_next = '0;
                    preempt_next  = 1'b1;
                end else if (hold_cnt_reg != HOLD_LAST) begin
                    hold_cnt_next = hold_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                gnt_next   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            gnt_reg       <= 8'd0;
            gnt_id_reg    <= 3'd0;
            gnt_valid_reg <= 1'b0;
            preempt_reg   <= 1'b0;
            ptr_reg       <= 3'd0;
            hold_cnt_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            gnt_reg       <= gnt_next;
            gnt_id_reg    <= gnt_id_next;
            gnt_valid_reg <= (gnt_next != 8'd0);
            preempt_reg   <= preempt_next;
            ptr_reg       <= ptr_next;
            hold_cnt_reg  <= hold_cnt_next;
        end
    end

    assign gnt       = gnt_reg;
    assign gnt_id    = gnt_id_reg;
    assign gnt_valid = gnt_valid_reg;
    assign preempt   = preempt_reg;
endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8 (MAX_HOLD=4): directed scenarios plus random request traffic,
// compared against a tenure-based round-robin model.

module tb_rr_arbiter8;
    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'hFF;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       any_req;
    logic       preempt;

    int checks = 0;
    int errors = 0;

    // Model state: holder (-1 = idle), scan start, cycles of grant seen so far.
    int holder = -1;
    int start = 0;
    int tenure = 0;
    logic exp_preempt = 1'b0;

    rr_arbiter8 #(.MAX_HOLD(MAX_HOLD), .HOLD_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .any_req   (any_req),
        .preempt   (preempt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_gnt();
        logic [7:0] one = 8'd1;
        return (holder < 0) ? 8'd0 : (one << holder);
    endfunction

    function automatic int pick(input logic [7:0] m, input int s);
        for (int k = 0; k < 8; k++) begin
            if (m[(s + k) % 8]) return (s + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_reset();
        holder = -1; start = 0; tenure = 0; exp_preempt = 1'b0;
    endtask

    task automatic model_grant(input int w);
        holder = w; start = (w + 1) % 8; tenure = 1;
    endtask

    task automatic model_edge(input logic [7:0] r);
        logic [7:0] others;
        exp_preempt = 1'b0;
        if (holder < 0) begin
            if (r != 8'd0) model_grant(pick(r, start));
        end else begin
            others = r;
            others[holder] = 1'b0;
            if (!r[holder]) begin
                if (others != 8'd0) model_grant(pick(others, start));
                else holder = -1;
            end else if (tenure >= MAX_HOLD && others != 8'd0) begin
                model_grant(pick(others, start));
                exp_preempt = 1'b1;
            end else if (tenure < MAX_HOLD) begin
                tenure++;
            end
        end
    endtask

    task automatic drive(input logic [7:0] r);
        @(negedge clk);
        req = r;
        @(posedge clk);
        model_edge(r);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (gnt !== 8'h00 || gnt_valid !== 1'b0 || preempt !== 1'b0 || gnt_id !== 3'd0) begin
                errors++;
                $display("FAIL reset: gnt=%h valid=%b preempt=%b id=%0d, expected all zero",
                         gnt, gnt_valid, preempt, gnt_id);
            end
        end
        req = 8'h00;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        drive(8'h04);
        checks++;
        if (gnt !== 8'h04 || gnt_id !== 3'd2 || gnt_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: gnt=%h id=%0d valid=%b, expected gnt=04 id=2 valid=1",
                     gnt, gnt_id, gnt_valid);
        end
        drive(8'h00);
        checks++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0 || gnt !== exp_gnt()) begin
            errors++;
            $display("FAIL single_release: gnt=%h valid=%b, expected gnt=00 valid=0", gnt, gnt_valid);
        end
    endtask

    task automatic test_rotation();
        logic [7:0] r;
        logic [7:0] want;
        do_reset();
        r = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            drive(r);
            want = 8'd1 << (i % 8);
            checks++;
            if (gnt !== want || gnt !== exp_gnt() || gnt_id !== 3'(i % 8) || preempt !== 1'b0) begin
                errors++;
                $display("FAIL rotation[%0d]: gnt=%h id=%0d preempt=%b, expected gnt=%h id=%0d preempt=0",
                         i, gnt, gnt_id, preempt, want, i % 8);
            end
            r = 8'hFF & ~want;
        end
    endtask

    task automatic test_timeout();
        logic [7:0] want;
        logic       want_pre;
        do_reset();
        for (int i = 0; i < 18; i++) begin
            drive(8'h09);
            want = (((i / MAX_HOLD) % 2) != 0) ? 8'h08 : 8'h01;
            want_pre = (i > 0) && (i % MAX_HOLD == 0);
            checks++;
            if (gnt !== want || preempt !== want_pre || gnt !== exp_gnt() || preempt !== exp_preempt) begin
                errors++;
                $display("FAIL timeout[%0d]: gnt=%h preempt=%b, expected gnt=%h preempt=%b",
                         i, gnt, preempt, want, want_pre);
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 40; i++) begin
            drive(8'h20);
            checks++;
            if (gnt !== 8'h20 || preempt !== 1'b0 || gnt_id !== 3'd5) begin
                errors++;
                $display("FAIL saturation[%0d]: gnt=%h id=%0d preempt=%b, expected gnt=20 id=5 preempt=0",
                         i, gnt, gnt_id, preempt);
            end
        end
        drive(8'h22);
        checks++;
        if (gnt !== 8'h02 || gnt_id !== 3'd1 || preempt !== 1'b1 || gnt !== exp_gnt()) begin
            errors++;
            $display("FAIL saturation_rotate: gnt=%h id=%0d preempt=%b, expected gnt=02 id=1 preempt=1",
                     gnt, gnt_id, preempt);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) drive(8'h20);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0 || preempt !== 1'b0 || gnt_id !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid_async: gnt=%h valid=%b preempt=%b id=%0d, expected all zero",
                     gnt, gnt_valid, preempt, gnt_id);
        end
        @(negedge clk);
        req = 8'h21;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        drive(8'h21);
        checks++;
        if (gnt !== 8'h01 || gnt_id !== 3'd0 || gnt_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_ptr: gnt=%h id=%0d valid=%b, expected gnt=01 id=0 valid=1",
                     gnt, gnt_id, gnt_valid);
        end
    endtask

    task automatic test_random();
        logic [7:0] r;
        do_reset();
        r = 8'h00;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: r = 8'($urandom_range(0, 255));
                1: r = r;
                2: if (holder >= 0) r[holder] = 1'b0;
                default: r[$urandom_range(0, 7)] = 1'b1;
            endcase
            drive(r);
            checks++;
            if (gnt !== exp_gnt() || gnt_valid !== (holder >= 0) || preempt !== exp_preempt
                || (holder >= 0 && gnt_id !== 3'(holder)) || !$onehot0(gnt)) begin
                errors++;
                $display("FAIL random[%0d]: req=%h gnt=%h id=%0d valid=%b preempt=%b, expected gnt=%h preempt=%b",
                         i, r, gnt, gnt_id, gnt_valid, preempt, exp_gnt(), exp_preempt);
            end
            checks++;
            if (any_req !== (r != 8'd0)) begin
                errors++;
                $display("FAIL any_req[%0d]: got %b, expected %b", i, any_req, r != 8'd0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_timeout();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
